// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, flag bit
// positions, FSM states and the opcode-to-decode-line helper.
package alu_issue_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_NOP = 3'd0,
      OP_ADD = 3'd1,
      OP_SUB = 3'd2,
      OP_INC = 3'd3,
      OP_DEC = 3'd4,
      OP_AND = 3'd5,
      OP_OR  = 3'd6,
      OP_NOT = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 2;

   function automatic logic [7:0] decode_onehot(input op_t opc);
      return 8'(1) << opc;
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, result and datapath signals of the ALU issue controller.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the source holds valid and payload stable until then, and ready never depends on
// anything but the receiver's own state.
interface alu_issue_ctrl_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_opcode;
   logic [7:0] in_op1;
   logic [7:0] in_op2;
   logic [7:0] alu_op1;
   logic [7:0] alu_op2;
   logic [7:0] alu_d;
   logic [7:0] alu_res;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_res;
   logic [2:0] out_flags;

   modport master (
      input  in_valid, in_opcode, in_op1, in_op2, alu_res, out_ready,
      output in_ready, alu_op1, alu_op2, alu_d, out_valid, out_res, out_flags
   );

   modport slave (
      output in_valid, in_opcode, in_op1, in_op2, alu_res, out_ready,
      input  in_ready, alu_op1, alu_op2, alu_d, out_valid, out_res, out_flags
   );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational {V,N,Z} generation from the captured result and the latched
// operands; V uses the effective second operand the adder actually saw.
module alu_flag_gen
   import alu_issue_ctrl_pkg::*;
(
   input  op_t        opcode,
   input  logic [7:0] a,
   input  logic [7:0] op2,
   input  logic [7:0] r,
   output logic [2:0] flags
);

   logic [7:0] b_eff;
   logic       v_en;

   always_comb begin
      b_eff = 8'h00;
      v_en  = 1'b0;
      case (opcode)
         OP_ADD: begin b_eff = op2;   v_en = 1'b1; end
         OP_SUB: begin b_eff = ~op2;  v_en = 1'b1; end
         OP_INC: begin b_eff = 8'h01; v_en = 1'b1; end
         OP_DEC: begin b_eff = 8'hFF; v_en = 1'b1; end
         default: begin b_eff = 8'h00; v_en = 1'b0; end
      endcase
      flags         = 3'b000;
      flags[FLAG_Z] = (r == 8'h00);
      flags[FLAG_N] = r[7];
      flags[FLAG_V] = v_en && (a[7] == b_eff[7]) && (r[7] != a[7]);
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts an ALU request, drives operands and one-hot decode
// lines for ALU_LAT cycles, then captures the result and flags for the consumer.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int ALU_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   alu_issue_ctrl_if.master bus,
   output logic             busy,
   output logic [CNT_W-1:0] op_count,
   output state_t           state_dbg
);

   state_t           state_q, state_d;
   op_t              opc_q, opc_d;
   logic [7:0]       op1_q, op1_d;
   logic [7:0]       op2_q, op2_d;
   logic [3:0]       lat_q, lat_d;
   logic [7:0]       res_q, res_d;
   logic [2:0]       flags_q, flags_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       flags_w;

   alu_flag_gen u_flag_gen (
      .opcode (opc_q),
      .a      (op1_q),
      .op2    (op2_q),
      .r      (bus.alu_res),
      .flags  (flags_w)
   );

   always_comb begin
      state_d = state_q;
      opc_d   = opc_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      lat_d   = lat_q;
      res_d   = res_q;
      flags_d = flags_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               opc_d   = op_t'(bus.in_opcode);
               op1_d   = bus.in_op1;
               op2_d   = bus.in_op2;
               lat_d   = 4'(ALU_LAT - 1);
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (lat_q != 4'd0) begin
               lat_d = lat_q - 4'd1;
            end else begin
               res_d   = bus.alu_res;
               flags_d = flags_w;
               valid_d = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               valid_d = 1'b0;
               cnt_d   = cnt_q + 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         opc_q   <= OP_NOP;
         op1_q   <= 8'h00;
         op2_q   <= 8'h00;
         lat_q   <= 4'd0;
         res_q   <= 8'h00;
         flags_q <= 3'b000;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         lat_q   <= lat_d;
         res_q   <= res_d;
         flags_q <= flags_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   // Decode lines are live only in DRIVE so the datapath's enable gating yields 0 elsewhere.
   assign bus.alu_d     = (state_q == ST_DRIVE) ? decode_onehot(opc_q) : 8'h00;
   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.alu_op1   = op1_q;
   assign bus.alu_op2   = op2_q;
   assign bus.out_valid = valid_q;
   assign bus.out_res   = res_q;
   assign bus.out_flags = flags_q;
   assign busy          = (state_q != ST_IDLE);
   assign op_count      = cnt_q;
   assign state_dbg     = state_q;

endmodule
